// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with optional parity and stop-bit checking
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);
    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [EW-1:0] E_SA   = EW'(OVERSAMPLE / 2 - 1);
    localparam logic [EW-1:0] E_RES  = EW'(OVERSAMPLE / 2);
    localparam logic [EW-1:0] E_LAST = EW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state, state_nxt;
    logic                    rx_meta, rx_s;
    logic [EW-1:0]           edge_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    par_en_l, par_typ_l, samp_a, glitch, par_bad, hold;
    logic                    res, last, bit_val, start, dv_nxt, pe_nxt, se_nxt;

    // The third majority sample is the value rx_s takes next cycle (rx_meta),
    // so the bit resolves one edge early and the registered outputs land on
    // the cycle of edge OVERSAMPLE/2+1.
    assign res     = edge_cnt == E_RES;
    assign last    = edge_cnt == E_LAST;
    assign bit_val = (samp_a & rx_s) | (samp_a & rx_meta) | (rx_s & rx_meta);
    assign start   = state == IDLE && !rx_s && !hold;
    assign busy    = state != IDLE;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and frame verdict; the return to IDLE at mid-stop allows
    // back-to-back frames without an idle gap
    always_comb begin
        state_nxt = state;
        dv_nxt    = 1'b0;
        pe_nxt    = 1'b0;
        se_nxt    = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = START;
            START:   if (last) state_nxt = glitch ? IDLE : DATA;
            DATA:    if (last && bit_cnt == B_LAST) state_nxt = par_en_l ? PARITY : STOP;
            PARITY:  if (last) state_nxt = STOP;
            STOP: begin
                if (res) begin
                    state_nxt = IDLE;
                    dv_nxt    = bit_val && !par_bad;
                    pe_nxt    = par_bad;
                    se_nxt    = !bit_val;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Synchronizer, counters, sampling, shifting and output registers;
    // hold blocks a restart on the same low level after a stop error
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            samp_a     <= 1'b1;
            glitch     <= 1'b0;
            par_bad    <= 1'b0;
            hold       <= 1'b0;
        end else begin
            rx_meta    <= RX_IN;
            rx_s       <= rx_meta;
            Data_Valid <= dv_nxt;
            par_err    <= pe_nxt;
            stp_err    <= se_nxt;
            if (dv_nxt) P_DATA <= shift_reg;
            edge_cnt   <= state == IDLE ? EW'(start) : (last ? '0 : edge_cnt + 1'b1);
            bit_cnt    <= state != DATA ? '0 : bit_cnt + BW'(last);
            if (edge_cnt == E_SA) samp_a <= rx_s;
            if (start) begin
                par_en_l  <= PAR_EN;
                par_typ_l <= PAR_TYP;
                par_bad   <= 1'b0;
            end
            if (res && state == START) glitch <= bit_val;
            if (res && state == DATA) shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
            if (res && state == PARITY) par_bad <= bit_val != (^shift_reg ^ par_typ_l);
            hold       <= se_nxt | (hold & !rx_s);
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed checks of the UART frame receiver
module tb_uart_rx_frame;
    localparam int OS = 8;

    logic       clk = 1'b0;
    logic       rst, RX_IN, PAR_EN, PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid, par_err, stp_err, busy;

    int checks = 0, failures = 0, cyc = 0;
    int dv_cnt = 0, pe_cnt = 0, se_cnt = 0;
    logic [7:0] dv_data[$];
    int         dv_cyc[$];

    uart_rx_frame #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .Data_Valid(Data_Valid), .par_err(par_err),
        .stp_err(stp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (Data_Valid) begin
            dv_cnt++;
            dv_data.push_back(P_DATA);
            dv_cyc.push_back(cyc);
        end
        if (par_err) pe_cnt++;
        if (stp_err) se_cnt++;
    end

    task automatic drive_bit(input logic v);
        RX_IN = v;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic sb);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) drive_bit(pb);
        drive_bit(sb);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        checks += 5;
        if (P_DATA !== 8'h00) begin failures++; $display("FAIL reset_pdata got=%h exp=00", P_DATA); end
        if (Data_Valid !== 1'b0) begin failures++; $display("FAIL reset_dv got=%b exp=0", Data_Valid); end
        if (par_err !== 1'b0) begin failures++; $display("FAIL reset_par got=%b exp=0", par_err); end
        if (stp_err !== 1'b0) begin failures++; $display("FAIL reset_stp got=%b exp=0", stp_err); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    // Good frame without parity; Data_Valid lands 78 cycles after the first low sample
    task automatic test_basic;
        int d0, e0, t0, lat;
        d0 = dv_cnt; e0 = pe_cnt + se_cnt;
        PAR_EN = 1'b0;
        t0 = cyc + 1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(4);
        lat = dv_cnt > d0 ? dv_cyc[d0] - t0 : -1;
        checks += 5;
        if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL basic_dv_count got=%0d exp=1", dv_cnt - d0); end
        if (P_DATA !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", P_DATA); end
        if (lat !== 78) begin failures++; $display("FAIL basic_latency got=%0d exp=78", lat); end
        if (pe_cnt + se_cnt - e0 !== 0) begin failures++; $display("FAIL basic_err got=%0d exp=0", pe_cnt + se_cnt - e0); end
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy); end
    endtask

    // Even parity good and bad, then odd parity with mid-frame config changes ignored
    task automatic test_parity;
        int d0, p0, s0, t0, lat;
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        t0 = cyc + 1;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        idle(4);
        lat = dv_cnt > d0 ? dv_cyc[d0] - t0 : -1;
        checks += 3;
        if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL par_good_dv got=%0d exp=1", dv_cnt - d0); end
        if (P_DATA !== 8'h3C) begin failures++; $display("FAIL par_good_data got=%h exp=3c", P_DATA); end
        if (lat !== 86) begin failures++; $display("FAIL par_latency got=%0d exp=86", lat); end
        d0 = dv_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle(4);
        checks += 4;
        if (pe_cnt - p0 !== 1) begin failures++; $display("FAIL par_bad_perr got=%0d exp=1", pe_cnt - p0); end
        if (dv_cnt - d0 !== 0) begin failures++; $display("FAIL par_bad_dv got=%0d exp=0", dv_cnt - d0); end
        if (P_DATA !== 8'h3C) begin failures++; $display("FAIL par_bad_data got=%h exp=3c", P_DATA); end
        if (se_cnt - s0 !== 0) begin failures++; $display("FAIL par_bad_stp got=%0d exp=0", se_cnt - s0); end
        d0 = dv_cnt; p0 = pe_cnt; s0 = se_cnt;
        PAR_TYP = 1'b1;
        fork
            send_frame(8'h07, 1'b1, 1'b0, 1'b1);
            begin
                repeat (20) @(negedge clk);
                PAR_TYP = 1'b0;
                PAR_EN  = 1'b0;
            end
        join
        idle(4);
        checks += 3;
        if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL par_latch_dv got=%0d exp=1", dv_cnt - d0); end
        if (P_DATA !== 8'h07) begin failures++; $display("FAIL par_latch_data got=%h exp=07", P_DATA); end
        if (pe_cnt + se_cnt - p0 - s0 !== 0) begin failures++; $display("FAIL par_latch_err got=%0d exp=0", pe_cnt + se_cnt - p0 - s0); end
    endtask

    // Stop bit low flags stp_err and leaves P_DATA alone; the next frame is fine
    task automatic test_stop;
        int d0, s0;
        d0 = dv_cnt; s0 = se_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        idle(10);
        checks += 3;
        if (se_cnt - s0 !== 1) begin failures++; $display("FAIL stop_serr got=%0d exp=1", se_cnt - s0); end
        if (dv_cnt - d0 !== 0) begin failures++; $display("FAIL stop_dv got=%0d exp=0", dv_cnt - d0); end
        if (P_DATA !== 8'h07) begin failures++; $display("FAIL stop_data got=%h exp=07", P_DATA); end
        d0 = dv_cnt; s0 = se_cnt;
        send_frame(8'h42, 1'b0, 1'b0, 1'b1);
        idle(4);
        checks += 3;
        if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL stop_next_dv got=%0d exp=1", dv_cnt - d0); end
        if (P_DATA !== 8'h42) begin failures++; $display("FAIL stop_next_data got=%h exp=42", P_DATA); end
        if (se_cnt - s0 !== 0) begin failures++; $display("FAIL stop_next_serr got=%0d exp=0", se_cnt - s0); end
    endtask

    // Line held low far beyond a frame gives exactly one stp_err and no restart
    task automatic test_break;
        int d0, s0;
        d0 = dv_cnt; s0 = se_cnt;
        RX_IN = 1'b0;
        repeat (200) @(negedge clk);
        checks += 3;
        if (se_cnt - s0 !== 1) begin failures++; $display("FAIL break_serr got=%0d exp=1", se_cnt - s0); end
        if (dv_cnt - d0 !== 0) begin failures++; $display("FAIL break_dv got=%0d exp=0", dv_cnt - d0); end
        if (busy !== 1'b0) begin failures++; $display("FAIL break_busy got=%b exp=0", busy); end
        idle(10);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        idle(4);
        checks += 2;
        if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL break_next_dv got=%0d exp=1", dv_cnt - d0); end
        if (P_DATA !== 8'h5A) begin failures++; $display("FAIL break_next_data got=%h exp=5a", P_DATA); end
    endtask

    // Short low glitch is dropped silently
    task automatic test_glitch;
        int d0, e0;
        d0 = dv_cnt; e0 = pe_cnt + se_cnt;
        RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_hi got=%b exp=1", busy); end
        idle(10);
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_lo got=%b exp=0", busy); end
        if (dv_cnt - d0 !== 0) begin failures++; $display("FAIL glitch_dv got=%0d exp=0", dv_cnt - d0); end
        if (pe_cnt + se_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_err got=%0d exp=0", pe_cnt + se_cnt - e0); end
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        idle(4);
        checks += 2;
        if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL glitch_next_dv got=%0d exp=1", dv_cnt - d0); end
        if (P_DATA !== 8'h11) begin failures++; $display("FAIL glitch_next_data got=%h exp=11", P_DATA); end
    endtask

    // Three frames with no idle gap, pulses 80 cycles apart
    task automatic test_back_to_back;
        int d0;
        logic [7:0] exp_d[3];
        exp_d = '{8'h00, 8'hFF, 8'h55};
        d0 = dv_cnt;
        for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b0, 1'b0, 1'b1);
        idle(4);
        checks++;
        if (dv_cnt - d0 !== 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", dv_cnt - d0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dv_data[d0+i] !== exp_d[i]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", i, dv_data[d0+i], exp_d[i]); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (dv_cyc[d0+i] - dv_cyc[d0+i-1] !== 10 * OS) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, dv_cyc[d0+i] - dv_cyc[d0+i-1], 10 * OS); end
            end
        end
    endtask

    // Reset during data bit 4 drops the frame; the next frame is received
    task automatic test_reset_mid;
        int d0, e0;
        d0 = dv_cnt; e0 = pe_cnt + se_cnt;
        fork
            send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
            begin
                repeat (44) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                checks += 3;
                if (P_DATA !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", P_DATA); end
                if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
                if (Data_Valid !== 1'b0) begin failures++; $display("FAIL rstmid_dv got=%b exp=0", Data_Valid); end
                rst = 1'b0;
            end
        join
        idle(10);
        checks += 2;
        if (dv_cnt - d0 !== 0) begin failures++; $display("FAIL rstmid_drop_dv got=%0d exp=0", dv_cnt - d0); end
        if (pe_cnt + se_cnt - e0 !== 0) begin failures++; $display("FAIL rstmid_drop_err got=%0d exp=0", pe_cnt + se_cnt - e0); end
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        idle(4);
        checks += 2;
        if (dv_cnt - d0 !== 1) begin failures++; $display("FAIL rstmid_next_dv got=%0d exp=1", dv_cnt - d0); end
        if (P_DATA !== 8'hC3) begin failures++; $display("FAIL rstmid_next_data got=%h exp=c3", P_DATA); end
    endtask

    initial begin
        rst = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        idle(5);
        test_basic;
        test_parity;
        test_stop;
        test_break;
        test_glitch;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
